// File: rtl/vec_unpack_writer.sv
// Captures a packed vector result and writes it out one lane per memory word, MSB lane first.
// Optional build macro VEC_UNPACK_SKIP_ZERO_EN: all-zero lanes are skipped (no write, address still advances).
module vec_unpack_writer #(
  parameter int LANES       = 16,
  parameter int LANE_W      = 8,
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] result_v,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic                    sign_ext,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WORD_W-1:0]       mem_wdata,
  input  logic                    mem_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int VEC_W = LANES * LANE_W;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t            state;
  logic [VEC_W-1:0]  data_q;
  logic              sign_q;
  logic [CNT_W-1:0]  lane_cnt;
  logic [VEC_W-1:0]  data_next;
  logic              last_lane;
  logic              advance;

  function automatic logic [WORD_W-1:0] extend(input logic [LANE_W-1:0] lane, input logic sx);
    logic [WORD_W-1:0] w;
    w = '0;
    w[LANE_W-1:0] = lane;
    for (int i = LANE_W; i < WORD_W; i++) w[i] = sx & lane[LANE_W-1];
    return w;
  endfunction

  function automatic logic lane_write(input logic [LANE_W-1:0] lane);
`ifdef VEC_UNPACK_SKIP_ZERO_EN
    return |lane;
`else
    return (lane == lane);
`endif
  endfunction

  // The captured vector shifts left so the current lane always sits in the top slice.
  assign data_next = data_q << LANE_W;
  assign last_lane = (lane_cnt == CNT_W'(LANES - 1));

`ifdef VEC_UNPACK_SKIP_ZERO_EN
  assign advance = mem_ready || !mem_we;
`else
  assign advance = mem_ready;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lane_cnt  <= '0;
      data_q    <= '0;
      sign_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q    <= result_v;
            sign_q    <= sign_ext;
            lane_cnt  <= '0;
            mem_addr  <= base_addr;
            mem_wdata <= extend(result_v[VEC_W-1 -: LANE_W], sign_ext);
            mem_we    <= lane_write(result_v[VEC_W-1 -: LANE_W]);
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (advance) begin
            if (last_lane) begin
              mem_we <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              lane_cnt  <= lane_cnt + CNT_W'(1);
              data_q    <= data_next;
              mem_addr  <= mem_addr + ADDR_W'(ADDR_STRIDE);
              mem_wdata <= extend(data_next[VEC_W-1 -: LANE_W], sign_q);
              mem_we    <= lane_write(data_next[VEC_W-1 -: LANE_W]);
            end
          end
        end
        DONE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_unpack_writer.sv
// Directed bench for vec_unpack_writer: transaction-level model with per-cycle compare plus literal pins.
module tb_vec_unpack_writer;
  localparam int LANES = 16, LANE_W = 8, WORD_W = 32, ADDR_W = 32, STRIDE = 4;
  localparam int VEC_W = LANES * LANE_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic sign_ext = 1'b0;
  logic mem_ready = 1'b1;
  logic [VEC_W-1:0]  result_v = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic in_ready, mem_we, busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  always #5 clk = ~clk;

  vec_unpack_writer #(.LANES(LANES), .LANE_W(LANE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W),
                      .ADDR_STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .result_v(result_v),
    .base_addr(base_addr), .sign_ext(sign_ext), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done));

  int checks = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_t;
  typedef enum {M_IDLE, M_WRITE, M_DONE} mphase_t;

  wr_t     exp_q[$];
  mphase_t m_phase = M_IDLE;
  int      cycle = 0;
  int      acc_q[$];
  bit      started = 0;

  function automatic void expand(input logic [VEC_W-1:0] v, input logic [ADDR_W-1:0] b, input logic sx);
    for (int i = 0; i < LANES; i++) begin
      logic [LANE_W-1:0] lane;
      wr_t e;
      lane = v[(LANES-1-i)*LANE_W +: LANE_W];
      e.addr = b + ADDR_W'(i * STRIDE);
      e.data = sx ? WORD_W'($signed(lane)) : WORD_W'(lane);
`ifdef VEC_UNPACK_SKIP_ZERO_EN
      e.we = (lane != 0);
`else
      e.we = 1'b1;
`endif
      exp_q.push_back(e);
    end
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (!rst) begin
      exp_q.delete();
      m_phase = M_IDLE;
    end else begin
      case (m_phase)
        M_IDLE: if (in_valid) begin
          expand(result_v, base_addr, sign_ext);
          acc_q.push_back(cycle);
          m_phase = M_WRITE;
        end
        M_WRITE: if (exp_q.size() > 0 && (!exp_q[0].we || mem_ready)) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_phase = M_DONE;
        end
        M_DONE: m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
    cycle++;
  end

  // ---------------- per-cycle compare and observation log ----------------
  logic [ADDR_W-1:0] obs_addr[$];
  logic [WORD_W-1:0] obs_data[$];
  int done_cnt = 0;
  int done_lat = -1;
  int ready_lat = -1;
  logic prev_in_ready = 1'b1;

  always @(negedge clk) begin
    if (started) begin
      logic e_we;
      e_we = (m_phase == M_WRITE) && (exp_q.size() > 0) && exp_q[0].we;
      chk("in_ready", 64'(in_ready), 64'(m_phase == M_IDLE));
      chk("busy", 64'(busy), 64'(m_phase != M_IDLE));
      chk("done", 64'(done), 64'(m_phase == M_DONE));
      chk("mem_we", 64'(mem_we), 64'(e_we));
      if (e_we && mem_we) begin
        chk("mem_addr", 64'(mem_addr), 64'(exp_q[0].addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(exp_q[0].data));
      end
      if (mem_we && mem_ready && rst) begin
        obs_addr.push_back(mem_addr);
        obs_data.push_back(mem_wdata);
      end
      if (done) begin
        done_cnt++;
        if (acc_q.size() > 0) done_lat = cycle - acc_q[$];
      end
      if (in_ready && !prev_in_ready && acc_q.size() > 0) ready_lat = cycle - acc_q[$];
      prev_in_ready = in_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_log();
    obs_addr.delete();
    obs_data.delete();
    done_lat = -1;
    ready_lat = -1;
  endtask

  task automatic send(input logic [VEC_W-1:0] v, input logic [ADDR_W-1:0] b, input logic sx);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_wait_timeout", 64'(n >= 200), 64'(0));
    result_v = v; base_addr = b; sign_ext = sx; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs after capture; the transaction must be unaffected.
    result_v = ~v; base_addr = 32'hDEAD_BEEF; sign_ext = ~sx;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", 64'(n >= 200), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(input logic [ADDR_W-1:0] a);
    int n = 0;
    while (!(mem_we && mem_addr == a) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("addr_wait_timeout", 64'(n >= 200), 64'(0));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int d0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_mem_addr", 64'(mem_addr), 64'(0));
    chk("reset_mem_wdata", 64'(mem_wdata), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic
    clear_log();
    send(128'h0102030405060708090A0B0C0D0E0F10, 32'h100, 1'b0);
    wait_done();
    chk("basic_nwrites", 64'(obs_addr.size()), 64'(16));
    if (obs_addr.size() == 16) begin
      chk("basic_addr0", 64'(obs_addr[0]), 64'h100);
      chk("basic_data0", 64'(obs_data[0]), 64'h1);
      chk("basic_addr15", 64'(obs_addr[15]), 64'h13C);
      chk("basic_data15", 64'(obs_data[15]), 64'h10);
    end
    chk("basic_done_lat", 64'(done_lat), 64'(17));
    chk("basic_ready_lat", 64'(ready_lat), 64'(18));

    // Extension
    for (int s = 1; s >= 0; s--) begin
      clear_log();
      send(128'h807F0102030405060708090A0B0C0D0E, 32'h200, s[0]);
      wait_done();
      chk("ext_nwrites", 64'(obs_data.size()), 64'(16));
      if (obs_data.size() == 16) begin
        chk("ext_lane0", 64'(obs_data[0]), s ? 64'hFFFFFF80 : 64'h00000080);
        chk("ext_lane1", 64'(obs_data[1]), 64'h0000007F);
      end
    end

    // Backpressure during lane 5
    clear_log();
    send(128'h1112131415161718191A1B1C1D1E1F20, 32'h400, 1'b1);
    wait_addr(32'h414);
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    wait_done();
    chk("bp_nwrites", 64'(obs_addr.size()), 64'(16));
    chk("bp_done_lat", 64'(done_lat), 64'(20));

    // Address wrap
    clear_log();
    send(128'hA1A2A3A4A5A6A7A8A9AAABACADAEAFB0, 32'hFFFF_FFF8, 1'b0);
    wait_done();
    if (obs_addr.size() >= 3) chk("wrap_addr2", 64'(obs_addr[2]), 64'h0);
    else chk("wrap_nwrites", 64'(obs_addr.size()), 64'(16));

    // Back-to-back with in_valid held high and result_v changing
    acc_q.delete();
    in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      result_v = {16{8'(k) | 8'h01}};
      base_addr = 32'h1000 + 32'(k * 16'h100);
      sign_ext = k[0];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    begin
      int n = 0;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    end
    chk("b2b_accepts", 64'(acc_q.size()), 64'(3));
    if (acc_q.size() >= 2) chk("b2b_spacing", 64'(acc_q[1] - acc_q[0]), 64'(18));

    // Reset mid-operation after lane 7 is written
    clear_log();
    d0 = done_cnt;
    send(128'h3132333435363738393A3B3C3D3E3F40, 32'h800, 1'b0);
    wait_addr(32'h81C);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst_mid_nwrites", 64'(obs_addr.size()), 64'(8));
    chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'(0));
    clear_log();
    send(128'h4142434445464748494A4B4C4D4E4F50, 32'h900, 1'b0);
    wait_done();
    if (obs_addr.size() > 0) chk("rst_fresh_addr0", 64'(obs_addr[0]), 64'h900);
    else chk("rst_fresh_nwrites", 64'(obs_addr.size()), 64'(16));

`ifdef VEC_UNPACK_SKIP_ZERO_EN
    clear_log();
    send(128'h000000AA0000000000000000BB000000, 32'hA00, 1'b0);
    wait_done();
    chk("skip_nwrites", 64'(obs_addr.size()), 64'(2));
    if (obs_addr.size() == 2) begin
      chk("skip_addr_a", 64'(obs_addr[0]), 64'hA0C);
      chk("skip_addr_b", 64'(obs_addr[1]), 64'hA30);
    end
    chk("skip_done_lat", 64'(done_lat), 64'(17));
    clear_log();
    d0 = done_cnt;
    send('0, 32'hB00, 1'b0);
    wait_done();
    chk("zero_nwrites", 64'(obs_addr.size()), 64'(0));
    chk("zero_done", 64'(done_cnt - d0), 64'(1));
`else
    clear_log();
    send('0, 32'hB00, 1'b1);
    wait_done();
    chk("zero_nwrites", 64'(obs_addr.size()), 64'(16));
    if (obs_data.size() > 0) chk("zero_data", 64'(obs_data[0]), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vec_unpack_writer.md
Name: vec_unpack_writer

Overview:
- Sequential successor to the combinational vector-result unpacker in the processor's vector writeback path.
- Captures one packed vector result of LANES lanes and splits it into lanes, MSB lane first.
- Extends each lane to WORD_W, zero- or sign-extended per transaction.
- Issues one data-memory word write per lane, at consecutive strided addresses, with memory backpressure.
- Frees the vector ALU as soon as the result is captured.

Parameters:
- LANES, 16: number of lanes in the packed result.
- LANE_W, 8: bits per lane. Constraint: LANE_W <= WORD_W.
- WORD_W, 32: memory word width.
- ADDR_W, 32: memory address width.
- ADDR_STRIDE, 4: address increment between consecutive lanes.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-low (asserted when rst==0).
- in_valid  input  1  result_v, base_addr and sign_ext are valid.
- in_ready  output  1  block can accept a new vector.
- result_v  input  LANES*LANE_W  packed vector result.
- base_addr  input  ADDR_W  address for lane 0.
- sign_ext  input  1  1 = sign-extend lanes, 0 = zero-extend.
- mem_we  output  1  write request to data memory.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  WORD_W  write data.
- mem_ready  input  1  memory accepts the write this cycle.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse: all lanes written.

Behaviour:
- Reset (rst==0 at a rising clk edge): state IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, lane counter=0, captured data cleared. Reset wins over every other event.
- Lane mapping: lane i = result_v[(LANES-1-i)*LANE_W +: LANE_W]. Lane 0 is the most significant slice.
- Lane i is written to base_addr + i*ADDR_STRIDE, modulo 2^ADDR_W (wraps silently).
- Extension:
  - sign_ext=1: upper WORD_W-LANE_W bits replicate the lane MSB.
  - sign_ext=0: upper bits are zero.
  - If LANE_W==WORD_W, no extension.
- States:
  - IDLE: in_ready=1, busy=0. On in_valid && in_ready, capture result_v, base_addr and sign_ext into internal registers, clear the lane counter, go to WRITE.
  - WRITE: in_ready=0, busy=1, mem_we=1. mem_addr and mem_wdata reflect the current lane and are stable while mem_ready=0.
    - On mem_ready=1 with lane counter < LANES-1: increment the counter; present the next lane the next cycle.
    - On mem_ready=1 at lane LANES-1: go to DONE.
  - DONE: mem_we=0, busy=1, done=1 for exactly one cycle, in_ready=0. Then IDLE.
- Latency with mem_ready tied high:
  - Accept at edge 0.
  - Lane 0 write in the cycle after edge 0; lane LANES-1 write in cycle LANES.
  - done in cycle LANES+1.
  - in_ready=1 again in cycle LANES+2.
- Inputs change after capture: no effect on the current transaction.
- in_valid while busy: ignored, no capture.
- Registered outputs: mem_addr and mem_wdata hold their last values when mem_we=0. The bench checks them only while mem_we=1.
- Reset mid-transaction: remaining writes are abandoned, done is not pulsed, and the block is in IDLE on the next cycle.

Optional Feature:
- Macro: VEC_UNPACK_SKIP_ZERO_EN.
- Defined:
  - In WRITE, a lane whose value is all zeros drives mem_we=0 for one cycle and advances without waiting for mem_ready.
  - Address still advances, so nonzero lanes keep their positional address.
  - done still pulses after lane LANES-1 is processed, including when every lane is zero (no writes issued).
- Not defined: every lane is written regardless of value.

Test Plan:
- Basic: result_v=128'h0102030405060708090A0B0C0D0E0F10, base_addr=0x100, sign_ext=0, mem_ready=1 -> 16 writes (0x100,0x00000001), (0x104,0x00000002) ... (0x13C,0x00000010); done in cycle 17 after accept; in_ready high again in cycle 18.
- Extension: lane 0 = 0x80, lane 1 = 0x7F -> sign_ext=1 gives 0xFFFFFF80, 0x0000007F; sign_ext=0 gives 0x00000080, 0x0000007F.
- Backpressure: mem_ready low for 3 cycles during lane 5 -> mem_addr=base+0x14 and mem_wdata held for 4 cycles; total writes 16; done delayed by 3 cycles.
- Busy/back-to-back: in_valid held high continuously with changing result_v -> second vector captured only in the IDLE cycle after done; its writes match the value present at that capture edge.
- Reset mid-op: rst=0 after the write of lane 7 -> next cycle mem_we=0, busy=0, in_ready=1, no done pulse; a fresh transaction afterwards starts at lane 0.
- Skip-zero (macro defined): result_v with only lanes 3 and 12 nonzero -> exactly 2 writes, at base+0x0C and base+0x30; done 17 cycles after accept with mem_ready=1. All-zero vector -> 0 writes, done still pulsed.
